// File: rtl/vx_bank_data_sched_pkg.sv
// Shared types and width helpers for the bank data-store scheduler.
package vx_bank_data_sched_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_RUN,
        ST_FLUSH
    } state_e;

    function automatic int sweep_cnt_width(input int lines);
        return (lines < 2) ? 1 : $clog2(lines);
    endfunction

    function automatic int wsel_width(input int words);
        return (words < 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/vx_bank_data_sched_if.sv
// Fill, core, response and data-store buses of one cache bank scheduler.
interface vx_bank_data_sched_if
    import vx_bank_data_sched_pkg::*;
#(
    parameter int LINES_PER_BANK = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int WORD_SIZE      = 4,
    parameter int NUM_PORTS      = 1,
    parameter int TAG_WIDTH      = 8
);
    localparam int LSEL       = sweep_cnt_width(LINES_PER_BANK);
    localparam int WSEL       = wsel_width(WORDS_PER_LINE);
    localparam int WORD_WIDTH = 8 * WORD_SIZE;
    localparam int LINE_WIDTH = WORDS_PER_LINE * WORD_WIDTH;

    logic                            fill_valid;
    logic                            fill_ready;
    logic [LSEL-1:0]                 fill_addr;
    logic [LINE_WIDTH-1:0]           fill_data;

    logic                            core_valid;
    logic                            core_ready;
    logic                            core_rw;
    logic [LSEL-1:0]                 core_addr;
    logic [NUM_PORTS*WSEL-1:0]       core_wsel;
    logic [NUM_PORTS-1:0]            core_pmask;
    logic [NUM_PORTS*WORD_SIZE-1:0]  core_byteen;
    logic [NUM_PORTS*WORD_WIDTH-1:0] core_data;
    logic [TAG_WIDTH-1:0]            core_tag;

    logic                            rsp_valid;
    logic                            rsp_ready;
    logic [TAG_WIDTH-1:0]            rsp_tag;
    logic [NUM_PORTS*WORD_WIDTH-1:0] rsp_data;

    logic                            da_stall;
    logic                            da_read;
    logic                            da_write;
    logic                            da_fill;
    logic [LSEL-1:0]                 da_addr;
    logic [NUM_PORTS*WSEL-1:0]       da_wsel;
    logic [NUM_PORTS-1:0]            da_pmask;
    logic [NUM_PORTS*WORD_SIZE-1:0]  da_byteen;
    logic [NUM_PORTS*WORD_WIDTH-1:0] da_write_data;
    logic [LINE_WIDTH-1:0]           da_fill_data;
    logic [NUM_PORTS*WORD_WIDTH-1:0] da_read_data;

    modport master (
        input  fill_valid, fill_addr, fill_data,
        output fill_ready,
        input  core_valid, core_rw, core_addr, core_wsel, core_pmask,
        input  core_byteen, core_data, core_tag,
        output core_ready,
        output rsp_valid, rsp_tag, rsp_data,
        input  rsp_ready,
        output da_stall, da_read, da_write, da_fill, da_addr, da_wsel,
        output da_pmask, da_byteen, da_write_data, da_fill_data,
        input  da_read_data
    );

    modport slave (
        output fill_valid, fill_addr, fill_data,
        input  fill_ready,
        output core_valid, core_rw, core_addr, core_wsel, core_pmask,
        output core_byteen, core_data, core_tag,
        input  core_ready,
        input  rsp_valid, rsp_tag, rsp_data,
        output rsp_ready,
        input  da_stall, da_read, da_write, da_fill, da_addr, da_wsel,
        input  da_pmask, da_byteen, da_write_data, da_fill_data,
        output da_read_data
    );

endinterface

// File: rtl/vx_bank_data_sched_arb.sv
// Fill-over-core priority arbiter; a waiting core request wins after
// STARVE_LIMIT consecutive fill grants.
module vx_bank_data_sched_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic fill_valid,
    input  logic core_valid,
    input  logic enable,
    output logic fill_ready,
    output logic core_ready,
    output logic fill_grant,
    output logic core_grant
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt_q;
    logic [SW-1:0] starve_cnt_d;
    logic          core_pri;

    always_comb begin
        core_pri     = core_valid && (starve_cnt_q == LIMIT);
        fill_ready   = enable & ~core_pri;
        core_ready   = enable & (~fill_valid | core_pri);
        fill_grant   = fill_valid & fill_ready;
        core_grant   = core_valid & core_ready;
        starve_cnt_d = starve_cnt_q;
        if (!core_valid || core_grant) begin
            starve_cnt_d = '0;
        end else if (fill_grant && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/vx_bank_data_sched.sv
// Bank data-store sequencer: zeroing sweeps, fill/core arbitration and a
// one-entry read-response stage that freezes the store under backpressure.
module vx_bank_data_sched
    import vx_bank_data_sched_pkg::*;
#(
    parameter int LINES_PER_BANK = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int WORD_SIZE      = 4,
    parameter int NUM_PORTS      = 1,
    parameter int TAG_WIDTH      = 8,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush_req,
    output logic                   flush_busy,
    vx_bank_data_sched_if.master   bus
);
    localparam int LSEL = sweep_cnt_width(LINES_PER_BANK);
    localparam logic [LSEL-1:0] LAST_LINE = LSEL'(LINES_PER_BANK - 1);

    state_e               state_q, state_d;
    logic [LSEL-1:0]      sweep_cnt_q, sweep_cnt_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d;

    logic stall;
    logic run_en;
    logic sweep_en;
    logic fill_ready;
    logic core_ready;
    logic fill_grant;
    logic core_grant;
    logic read_grant;

    assign stall    = rsp_valid_q & ~bus.rsp_ready;
    assign run_en   = (state_q == ST_RUN) & ~stall;
    assign sweep_en = (state_q != ST_RUN) & ~stall;

    vx_bank_data_sched_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .fill_valid (bus.fill_valid),
        .core_valid (bus.core_valid),
        .enable     (run_en),
        .fill_ready (fill_ready),
        .core_ready (core_ready),
        .fill_grant (fill_grant),
        .core_grant (core_grant)
    );

    assign read_grant = core_grant & ~bus.core_rw;

    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        case (state_q)
            ST_INIT, ST_FLUSH: begin
                if (sweep_en) begin
                    if (sweep_cnt_q == LAST_LINE) begin
                        sweep_cnt_d = '0;
                        state_d     = ST_RUN;
                    end else begin
                        sweep_cnt_d = sweep_cnt_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (flush_req) begin
                    state_d = ST_FLUSH;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // A new read always reloads the stage; it can only issue when not stalled.
        rsp_valid_d = read_grant | (rsp_valid_q & ~bus.rsp_ready);
        rsp_tag_d   = read_grant ? bus.core_tag : rsp_tag_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            sweep_cnt_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_tag_q   <= rsp_tag_d;
        end
    end

    assign flush_busy     = (state_q != ST_RUN);
    assign bus.fill_ready = fill_ready;
    assign bus.core_ready = core_ready;

    // Strobes are masked by reset_n so nothing reaches the store while in reset.
    assign bus.da_stall      = stall;
    assign bus.da_fill       = reset_n & (sweep_en | fill_grant);
    assign bus.da_read       = reset_n & read_grant;
    assign bus.da_write      = reset_n & core_grant & bus.core_rw;
    assign bus.da_addr       = sweep_en   ? sweep_cnt_q :
                               fill_grant ? bus.fill_addr : bus.core_addr;
    assign bus.da_fill_data  = sweep_en ? '0 : bus.fill_data;
    assign bus.da_wsel       = bus.core_wsel;
    assign bus.da_pmask      = bus.core_pmask;
    assign bus.da_byteen     = bus.core_byteen;
    assign bus.da_write_data = bus.core_data;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_data  = bus.da_read_data;

endmodule

// File: doc/vx_bank_data_sched.md
# VX_bank_data_sched

Per-bank scheduler that sequences the bank's line data store.
- Arbitrates between memory fill responses and core requests.
- Runs a line-zeroing sweep after reset and on flush.
- Drives one store operation per cycle and returns read data through a one-entry response stage with backpressure.
- Sits between the bank's request/fill queues and the data store, which has single-cycle registered read output.

## Interface
Parameters:
- LINES_PER_BANK, 64, lines in the store; power of two ≥ 2
- WORDS_PER_LINE, 4, words per line
- WORD_SIZE, 4, bytes per word; WORD_WIDTH = 8·WORD_SIZE
- NUM_PORTS, 1, core ports per request
- TAG_WIDTH, 8, core request tag width
- STARVE_LIMIT, 4, max consecutive fill grants while a core request waits; ≥ 1

Derived widths: LSEL = log2(LINES_PER_BANK); WSEL = max(1, log2(WORDS_PER_LINE)).

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- flush_req  in  1  single-cycle request to zero all lines
- flush_busy  out  1  high during the INIT and FLUSH sweeps
- fill_valid / fill_ready  in / out  1  fill handshake
- fill_addr  in  LSEL  line to fill
- fill_data  in  WORDS_PER_LINE·WORD_WIDTH  line data
- core_valid / core_ready  in / out  1  core handshake
- core_rw  in  1  1 = write, 0 = read
- core_addr  in  LSEL  line address
- core_wsel  in  NUM_PORTS·WSEL  word select per port
- core_pmask  in  NUM_PORTS  port enables
- core_byteen  in  NUM_PORTS·WORD_SIZE  write byte enables
- core_data  in  NUM_PORTS·WORD_WIDTH  write data
- core_tag  in  TAG_WIDTH  request tag
- rsp_valid / rsp_ready  out / in  1  read-response handshake
- rsp_tag  out  TAG_WIDTH  tag of the read being returned
- rsp_data  out  NUM_PORTS·WORD_WIDTH  read data
- da_stall  out  1  freezes the data store
- da_read, da_write, da_fill  out  1 each  operation strobes
- da_addr, da_wsel, da_pmask, da_byteen, da_write_data, da_fill_data  out  widths as the core/fill inputs  operation fields
- da_read_data  in  NUM_PORTS·WORD_WIDTH  store read data, valid one cycle after da_read

## Operation
State machine, reset state INIT:
- INIT: one zero-fill per unstalled cycle (da_fill=1, da_fill_data=0, da_addr=sweep_cnt).
  - When sweep_cnt reaches LINES_PER_BANK-1 and the cycle is unstalled: sweep_cnt wraps to 0 and the state moves to RUN.
- RUN: arbitration, see below.
  - flush_req=1 → FLUSH the next cycle.
  - An op granted in the same cycle as flush_req still issues.
- FLUSH: identical to INIT; returns to RUN.
  - flush_req in INIT/FLUSH is ignored, not queued.
- flush_busy = state ∈ {INIT, FLUSH}.

Stall and gating:
- stall = rsp_valid & ~rsp_ready; da_stall = stall.
- While stalled, or in INIT/FLUSH: fill_ready = core_ready = 0, and the sweep counter holds.
- All da_* strobes are gated by reset_n.

RUN arbitration (ready signals are combinational):
- Fill has priority, except when core_valid is set and starve_cnt == STARVE_LIMIT; then core is granted.
- starve_cnt increments on a fill grant while core_valid=1.
- starve_cnt clears on a core grant or whenever core_valid=0.
- starve_cnt saturates at STARVE_LIMIT.

Operation fields:
- Granted fill: da_fill=1; da_addr and da_fill_data come from the fill inputs.
- Granted core request: da_write=core_rw, da_read=~core_rw; addr, wsel, pmask, byteen and data pass through.
- No grant: all strobes are 0; field values are don't-care.

Response stage:
- Writes and fills produce no response.
- A granted read loads rsp_tag, and rsp_valid sets the next cycle with rsp_data = da_read_data.
- The store holds its output while da_stall is high, so rsp_data is stable while stalled.
- rsp_valid clears when rsp_ready=1 and no new read issued in the previous cycle.
- Back-to-back reads stream at one per cycle while rsp_ready=1.

## Timing
- Reset values: state=INIT, sweep_cnt=0, starve_cnt=0, rsp_valid=0, rsp_tag=0, fill_ready=0, core_ready=0, da_* strobes=0, flush_busy=1.
- After reset release, the init sweep takes LINES_PER_BANK unstalled cycles. flush_busy falls and ready signals may rise on cycle LINES_PER_BANK.
- Read latency: grant cycle N → rsp_valid at N+1.
- Reset asserted mid-sweep or mid-response: everything returns immediately to reset values and the sweep restarts at line 0.

## Structure
- VX_bank_sched_pkg holds:
  - the state enum {INIT, RUN, FLUSH}
  - a sweep-counter width function
- Sub-module VX_bank_sched_arb: two-way fill/core arbiter with the starvation counter.
  - Inputs: valids, enable. Outputs: grants.

## Test plan
1. Reset release with LINES_PER_BANK=64 → da_fill on lines 0..63 with zero data over 64 cycles; flush_busy=0 and fill_ready=1 on cycle 64.
2. Read of line 5, tag 0x3A, rsp_ready=1 → da_read at cycle N; rsp_valid, rsp_tag=0x3A and the line-5 word at N+1.
3. Continuous fills plus a pending core read, STARVE_LIMIT=4 → 4 fill grants, then 1 core grant, then fills resume.
4. rsp_ready=0 for 3 cycles with a response pending → da_stall=1, no grants, rsp_data stable; the response is accepted when rsp_ready returns to 1.
5. flush_req in RUN with a core write granted the same cycle → the write issues, then a 64-cycle zero sweep; a second flush_req mid-sweep is ignored.
6. reset_n low mid-FLUSH at line 20 → outputs return to reset values asynchronously; the sweep restarts from line 0.
